// File: rtl/clk_div_sched.sv
// clk_div_sched: round-robin sharing of one clock divider; divisor changes commit only on a period boundary.
// Optional CLK_DIV_SCHED_PREEMPT_EN lets a waiting requester take over after MAX_PERIODS wraps.
module clk_div_sched #(
  parameter logic [7:0] IDLE_DIV    = 8'd7,
  parameter logic [7:0] MAX_PERIODS = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] div_req,
  input  logic [7:0]  div_cnt,
  output logic [7:0]  divisor,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        wrap
);
  localparam int NUM_REQ = 4;
  localparam int VEC_W   = 8;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACT} state_t;

  state_t                        state, state_nxt;
  logic [NUM_REQ-1:0][VEC_W-1:0] div_lane;
  logic [1:0]                    owner, rr_ptr, win_idx, oth_idx;
  logic                          win_vld, oth_vld, own_req, preempt;
  logic [NUM_REQ-1:0]            others;
  logic [VEC_W-1:0]              pend_div, dwell;

  assign div_lane = div_req;

  // {found, index}: first set bit scanning ptr, ptr+1, ... mod NUM_REQ
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {win_vld, win_idx} = rr_pick(req, rr_ptr);
  assign own_req            = req[owner];
  assign wrap               = (div_cnt == divisor);

  always_comb begin
    others        = req;
    others[owner] = 1'b0;
  end
  assign {oth_vld, oth_idx} = rr_pick(others, rr_ptr);

`ifdef CLK_DIV_SCHED_PREEMPT_EN
  assign preempt = (state == S_ACT) && own_req && wrap && oth_vld &&
                   (({1'b0, dwell} + 9'd1) >= {1'b0, MAX_PERIODS});
`else
  logic unused_dwell;
  assign preempt      = 1'b0;
  assign unused_dwell = ^{dwell, MAX_PERIODS, oth_vld};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_PEND;
      S_PEND:  if (!own_req) state_nxt = S_IDLE;
               else if (wrap) state_nxt = S_ACT;
      S_ACT:   if (!own_req) state_nxt = win_vld ? S_PEND : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= IDLE_DIV;
      gnt      <= '0;
      rr_ptr   <= '0;
      dwell    <= '0;
      owner    <= '0;
      pend_div <= '0;
    end else begin
      case (state)
        S_IDLE: if (win_vld) begin
          owner    <= win_idx;
          pend_div <= div_lane[win_idx];
        end
        // abort (req dropped) wins over a coincident wrap
        S_PEND: if (own_req && wrap) begin
          divisor    <= pend_div;
          gnt        <= '0;
          gnt[owner] <= 1'b1;
          rr_ptr     <= owner + 2'd1;
          dwell      <= '0;
        end
        S_ACT: begin
          if (!own_req) begin
            gnt <= '0;
            if (win_vld) begin
              owner    <= win_idx;
              pend_div <= div_lane[win_idx];
            end
          end else if (preempt) begin
            divisor      <= div_lane[oth_idx];
            gnt          <= '0;
            gnt[oth_idx] <= 1'b1;
            owner        <= oth_idx;
            rr_ptr       <= oth_idx + 2'd1;
            dwell        <= '0;
          end else if (wrap && dwell != 8'hFF) begin
            dwell <= dwell + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Scheduler that shares one programmable clock divider between 4 requesters (LF modulators, sniffers, debug tap).
- Arbitrates round-robin and drives the divider's 8-bit divisor input.
- Observes the divider's 8-bit count and commits divisor changes only at a period boundary (count == divisor), so the divided clock never produces a truncated or stretched half-period.
- Sits between the mode-select logic and the divider instance.

Parameters:
- IDLE_DIV, 8'd7, divisor driven after reset until the first grant.
- MAX_PERIODS, 8'd16, wrap count after which a waiting requester may preempt the owner. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  4  per-requester request, level, held until granted or withdrawn
- div_req  in  32  requested divisors; requester i uses [8i+7:8i]
- div_cnt  in  8  current count fed back from the divider
- divisor  out  8  divisor driven to the divider, registered
- gnt  out  4  one-hot owner, registered; 0 = no owner
- busy  out  1  high when state is not IDLE
- wrap  out  1  combinational, div_cnt == divisor

Behaviour:
- Reset (sync, highest priority; also applies mid-operation): divisor=IDLE_DIV, gnt=0, state=IDLE, rr_ptr=0, dwell=0, pending owner/div cleared.
- States: IDLE, PENDING, ACTIVE.
- IDLE:
  - If req!=0, pick the winner as the first set bit scanning rr_ptr, rr_ptr+1, ... mod 4.
  - At that edge: latch owner index and div_req slice into pend_div; go to PENDING.
  - divisor holds its last value; gnt=0.
- PENDING:
  - If req[owner]==0: abort to IDLE; divisor and rr_ptr unchanged. This takes priority over a simultaneous wrap.
  - Else, on an edge with wrap==1: divisor<=pend_div, gnt<=onehot(owner), rr_ptr<=owner+1 mod 4, dwell<=0, go to ACTIVE.
  - wrap is evaluated against the old divisor, so the new divisor governs the whole next period.
- ACTIVE:
  - div_req changes from the owner are ignored; to change divisor, the owner must drop req and re-request.
  - On each wrap, dwell increments, saturating at 8'hFF.
  - If req[owner]==0: gnt<=0 at the next edge. Then go to PENDING if any other req is set (winner chosen from rr_ptr at that edge), else to IDLE.
  - No preemption without the optional feature.
- Latency: from req in IDLE to gnt is worst case 1 + (divisor+1) cycles; minimum 2 cycles.
- Equal divisor: if pend_div == current divisor, the boundary wait still applies; gnt still asserts only on wrap.
- div_cnt > divisor (divider mid-reload): no wrap; wait for the next match.
- At most one gnt bit is ever set; gnt!=0 only in ACTIVE.

Optional Feature:
- Macro: CLK_DIV_SCHED_PREEMPT_EN.
- Defined:
  - In ACTIVE, on a wrap edge where dwell+1 >= MAX_PERIODS and any other req is set: select the winner from rr_ptr, excluding the owner.
  - On that same edge: divisor<=that requester's div_req, gnt<=onehot(winner), rr_ptr<=winner+1, dwell<=0; stay in ACTIVE.
  - The preempted requester must wait for its next round-robin turn.
- Undefined:
  - The owner keeps the grant until it releases.
  - dwell counts but has no effect.

Test Plan:
- Reset: rst=1 for 2 cycles -> divisor=7, gnt=0, busy=0; after release, with req=0 and div_cnt sweeping, outputs stay constant.
- Single grant: req=4'b0100, div_req[23:16]=9, divider model counting 0..7 -> busy=1 after 1 cycle; gnt=4'b0100 and divisor=9 on the edge where div_cnt==7, never earlier; next period counts 0..9.
- Round robin: req=4'b1111, each owner drops req after 2 wraps -> grant order 0,1,2,3,0; exactly one gnt bit at any time.
- Abort: req[1] rises then falls before div_cnt reaches divisor; also a case where it falls on the wrap cycle itself -> no gnt, divisor unchanged, returns to IDLE.
- Preempt (macro defined, MAX_PERIODS=4): owner 0 holds req, req[1] set with div_req=5 -> at the 4th wrap, gnt goes 0001->0010 and divisor=5 on the same edge. Without the macro -> gnt stays 0001 indefinitely.
- Reset mid-PENDING: assert rst while waiting for wrap -> next edge divisor=7, gnt=0, state IDLE; the pending request is re-arbitrated from rr_ptr=0.
